// File: rtl/ixc_skid_pkg.sv
// ============================================================================
//  Module      : ixc_skid_pkg
//  Description : State encoding and occupancy helper for the ixc_skid_6 buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ixc_skid_pkg;

    localparam int IXC_SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    function automatic logic [1:0] skid_occupancy(input skid_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ONE:     occ = 2'd1;
            FULL:    occ = IXC_SKID_DEPTH[1:0];
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ixc_sat_cnt.sv
// ============================================================================
//  Module      : ixc_sat_cnt
//  Description : Saturating up-counter with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ixc_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ixc_skid_6.sv
// ============================================================================
//  Module      : ixc_skid_6
//  Description : 2-entry registered skid buffer feeding the ixc_assign_6 stage.
//                Optional statistics counters enabled by IXC_SKID_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ixc_skid_6
    import ixc_skid_pkg::*;
#(
    parameter int WIDTH = 6
`ifdef IXC_SKID_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
`ifdef IXC_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    skid_state_t      state_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;

    logic w_in_fire;
    logic w_out_fire;

    // in_ready depends only on rst and state, never on out_ready.
    assign in_ready   = !rst && (state_q != FULL);
    assign out_valid  = (state_q != EMPTY);
    assign out_data   = head_q;
    assign count      = skid_occupancy(state_q);

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_in_fire) begin
                        state_q <= ONE;
                        head_q  <= in_data;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        head_q  <= in_data;
                    end else if (w_in_fire) begin
                        state_q <= FULL;
                        skid_q  <= in_data;
                    end else if (w_out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // Head drains first; the skid entry moves up behind it.
                    if (w_out_fire) begin
                        state_q <= ONE;
                        head_q  <= skid_q;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

`ifdef IXC_SKID_STATS_EN
    logic w_stall;
    assign w_stall = in_valid && !in_ready && !rst;

    ixc_sat_cnt #(
        .W     (CNT_W)
    ) u_xfer_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_out_fire),
        .clr_i (1'b0),
        .cnt_o (xfer_cnt)
    );

    ixc_sat_cnt #(
        .W     (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_stall),
        .clr_i (1'b0),
        .cnt_o (stall_cnt)
    );
`endif

endmodule

`default_nettype wire
